// File: rtl/horner_sequencer_pkg.sv
// Shared types and constants for the Horner polynomial sequencer:
// FSM state encoding, ALU op codes and default sizing.
package horner_sequencer_pkg;

  localparam int WIDTH_DEF   = 8;
  localparam int MAX_DEG_DEF = 4;
  localparam int DEG_W_DEF   = 3;

  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_MUL = 1'b1;

  typedef enum logic [2:0] {
    S_LOAD_X      = 3'd0,
    S_LOAD_X_WAIT = 3'd1,
    S_LOAD_C      = 3'd2,
    S_LOAD_C_WAIT = 3'd3,
    S_INIT        = 3'd4,
    S_MUL         = 3'd5,
    S_ADD         = 3'd6
  } state_t;

endpackage

// File: rtl/horner_sequencer_alu.sv
// Shared add/multiply unit; both results are truncated to WIDTH bits.
module poly_alu
  import horner_sequencer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  output logic [WIDTH-1:0] y
);

  logic [WIDTH-1:0] prod;
  logic [WIDTH-1:0] sum;

  assign prod = a * b;
  assign sum  = a + b;
  assign y    = (op == ALU_MUL) ? prod : sum;

endmodule

// File: rtl/horner_sequencer.sv
// Loads x and deg+1 coefficients (highest power first) over a Go handshake,
// then evaluates p(x) by Horner's rule on one time-shared ALU.
module horner_sequencer
  import horner_sequencer_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int MAX_DEG = MAX_DEG_DEF,
  parameter int DEG_W   = DEG_W_DEF
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             Go,
  input  logic [WIDTH-1:0] DataIn,
  input  logic [DEG_W-1:0] Degree,
  output logic [WIDTH-1:0] DataResult,
  output logic             Done,
  output logic             Busy,
  output logic [DEG_W-1:0] CoefIdx
);

  localparam logic [DEG_W-1:0] ONE = DEG_W'(1);

  state_t           state, next_state;
  logic [WIDTH-1:0] x_r;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] coef [MAX_DEG+1];
  logic [DEG_W-1:0] deg_r;
  logic [DEG_W-1:0] idx;
  logic [DEG_W-1:0] i_r;
  logic [DEG_W-1:0] i_m1;
  logic [WIDTH-1:0] alu_b;
  logic             alu_op;
  logic [WIDTH-1:0] alu_y;

  function automatic logic [DEG_W-1:0] clamp_deg(input logic [DEG_W-1:0] d);
    return (d > DEG_W'(MAX_DEG)) ? DEG_W'(MAX_DEG) : d;
  endfunction

  assign i_m1 = i_r - ONE;

  poly_alu #(.WIDTH(WIDTH)) u_alu (
    .a  (acc),
    .b  (alu_b),
    .op (alu_op),
    .y  (alu_y)
  );

  always_comb begin
    next_state = state;
    alu_op     = ALU_ADD;
    alu_b      = '0;
    Busy       = 1'b0;
    CoefIdx    = '0;
    case (state)
      S_LOAD_X:      if (Go) next_state = S_LOAD_X_WAIT;
      S_LOAD_X_WAIT: if (!Go) next_state = S_LOAD_C;
      S_LOAD_C: begin
        CoefIdx = idx;
        if (Go) next_state = S_LOAD_C_WAIT;
      end
      S_LOAD_C_WAIT: begin
        CoefIdx = idx;
        if (!Go) next_state = (idx == '0) ? S_INIT : S_LOAD_C;
      end
      S_INIT: begin
        Busy       = 1'b1;
        next_state = (deg_r == '0) ? S_LOAD_X : S_MUL;
      end
      S_MUL: begin
        Busy       = 1'b1;
        alu_op     = ALU_MUL;
        alu_b      = x_r;
        next_state = S_ADD;
      end
      S_ADD: begin
        Busy       = 1'b1;
        alu_op     = ALU_ADD;
        alu_b      = coef[i_m1];
        next_state = (i_m1 == '0) ? S_LOAD_X : S_MUL;
      end
      default: next_state = S_LOAD_X;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state      <= S_LOAD_X;
      x_r        <= '0;
      acc        <= '0;
      deg_r      <= '0;
      idx        <= '0;
      i_r        <= '0;
      DataResult <= '0;
      Done       <= 1'b0;
      for (int k = 0; k <= MAX_DEG; k++) coef[k] <= '0;
    end else begin
      state <= next_state;
      Done  <= 1'b0;
      case (state)
        S_LOAD_X: begin
          x_r   <= DataIn;
          deg_r <= clamp_deg(Degree);
        end
        S_LOAD_X_WAIT: if (!Go) idx <= deg_r;
        S_LOAD_C:      coef[idx] <= DataIn;
        S_LOAD_C_WAIT: if (!Go && idx != '0) idx <= idx - ONE;
        S_INIT: begin
          acc <= coef[deg_r];
          i_r <= deg_r;
          if (deg_r == '0) begin
            DataResult <= coef[0];
            Done       <= 1'b1;
          end
        end
        S_MUL: acc <= alu_y;
        S_ADD: begin
          acc <= alu_y;
          i_r <= i_m1;
          // Last accumulation goes straight to the result register.
          if (i_m1 == '0) begin
            DataResult <= alu_y;
            Done       <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_horner_sequencer.sv
// Randomised bench for horner_sequencer against a power-sum polynomial model.
module tb_horner_sequencer;

  logic       Clock;
  logic       Resetn;
  logic       Go;
  logic [7:0] DataIn;
  logic [2:0] Degree;
  logic [7:0] DataResult;
  logic       Done;
  logic       Busy;
  logic [2:0] CoefIdx;

  int vectors;
  int miscompares;
  int done_cyc;
  int busy_cnt;
  logic [2:0] idx_seen [$];

  horner_sequencer dut (
    .Clock      (Clock),
    .Resetn     (Resetn),
    .Go         (Go),
    .DataIn     (DataIn),
    .Degree     (Degree),
    .DataResult (DataResult),
    .Done       (Done),
    .Busy       (Busy),
    .CoefIdx    (CoefIdx)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // p(x) = sum c[k] * x^(n-k), c[0] is the highest power, all mod 256.
  function automatic logic [7:0] ref_eval(input logic [7:0] xv, input int n,
                                          input logic [7:0] c [5]);
    int unsigned sum;
    int unsigned t;
    sum = 0;
    for (int k = 0; k <= n; k++) begin
      t = c[k];
      for (int e = 0; e < n - k; e++) t = (t * xv) % 256;
      sum = (sum + t) % 256;
    end
    return 8'(sum);
  endfunction

  function automatic int eff_deg(input logic [2:0] d);
    return (d > 3'd4) ? 4 : int'(d);
  endfunction

  task automatic load_ops(input logic [7:0] xv, input logic [2:0] dv,
                          input logic [7:0] c [5], input int hold);
    int n;
    n = eff_deg(dv);
    idx_seen.delete();
    DataIn = xv;
    Degree = dv;
    Go     = 1'b1;
    @(posedge Clock); #1;
    for (int h = 1; h < hold; h++) begin
      DataIn = 8'($urandom);
      Degree = 3'($urandom_range(7, 0));
      @(posedge Clock); #1;
    end
    Go     = 1'b0;
    DataIn = 8'($urandom);
    @(posedge Clock); #1;
    for (int k = 0; k <= n; k++) begin
      idx_seen.push_back(CoefIdx);
      DataIn = c[k];
      Go     = 1'b1;
      @(posedge Clock); #1;
      for (int h = 1; h < hold; h++) begin
        DataIn = 8'($urandom);
        Degree = 3'($urandom_range(7, 0));
        @(posedge Clock); #1;
      end
      Go     = 1'b0;
      DataIn = 8'($urandom);
      @(posedge Clock); #1;
    end
  endtask

  task automatic wait_result(input bit noise);
    done_cyc = -1;
    busy_cnt = 0;
    for (int cyc = 0; cyc < 64; cyc++) begin
      if (Done) begin
        done_cyc = cyc;
        break;
      end
      if (Busy) busy_cnt++;
      if (noise) Go = 1'($urandom);
      @(posedge Clock); #1;
    end
    Go = 1'b0;
  endtask

  task automatic test_reset;
    Resetn = 1'b0;
    Go     = 1'b0;
    DataIn = 8'hA5;
    Degree = 3'd2;
    repeat (3) @(posedge Clock);
    #1;
    vectors++;
    if (DataResult !== 8'h00 || Done !== 1'b0 || Busy !== 1'b0 || CoefIdx !== 3'd0) begin
      miscompares++;
      $display("FAIL reset: res=%h done=%b busy=%b idx=%0d required 00/0/0/0",
               DataResult, Done, Busy, CoefIdx);
    end
    Resetn = 1'b1;
    @(posedge Clock); #1;
  endtask

  task automatic test_quadratic;
    logic [7:0] c [5];
    c = '{8'd2, 8'd3, 8'd4, 8'd0, 8'd0};
    load_ops(8'd3, 3'd2, c, 1);
    wait_result(1'b0);
    vectors++;
    if (DataResult !== ref_eval(8'd3, 2, c)) begin
      miscompares++;
      $display("FAIL quad_result: got %h want %h", DataResult, ref_eval(8'd3, 2, c));
    end
    vectors++;
    if (done_cyc !== 5 || busy_cnt !== 5) begin
      miscompares++;
      $display("FAIL quad_timing: done_cyc=%0d busy=%0d want 5/5", done_cyc, busy_cnt);
    end
    vectors++;
    if (idx_seen.size() !== 3 || idx_seen[0] !== 3'd2 || idx_seen[1] !== 3'd1 ||
        idx_seen[2] !== 3'd0) begin
      miscompares++;
      $display("FAIL quad_coefidx: size=%0d want sequence 2,1,0", idx_seen.size());
    end
    @(posedge Clock); #1;
    vectors++;
    if (Done !== 1'b0 || DataResult !== 8'h1F) begin
      miscompares++;
      $display("FAIL quad_hold: done=%b res=%h want 0/1f", Done, DataResult);
    end
  endtask

  task automatic test_deg0;
    logic [7:0] c [5];
    logic [7:0] xv;
    c  = '{8'h5A, 8'h00, 8'h00, 8'h00, 8'h00};
    xv = 8'($urandom);
    load_ops(xv, 3'd0, c, 1);
    wait_result(1'b0);
    vectors++;
    if (DataResult !== 8'h5A || done_cyc !== 1 || busy_cnt !== 1) begin
      miscompares++;
      $display("FAIL deg0: res=%h done_cyc=%0d busy=%0d want 5a/1/1",
               DataResult, done_cyc, busy_cnt);
    end
    vectors++;
    if (idx_seen.size() !== 1 || idx_seen[0] !== 3'd0) begin
      miscompares++;
      $display("FAIL deg0_loads: count=%0d want 1", idx_seen.size());
    end
  endtask

  task automatic test_wrap;
    logic [7:0] c [5];
    c = '{8'd1, 8'd0, 8'd0, 8'd0, 8'd0};
    load_ops(8'd16, 3'd2, c, 1);
    wait_result(1'b0);
    vectors++;
    if (DataResult !== 8'h00 || done_cyc !== 5) begin
      miscompares++;
      $display("FAIL wrap_mul: res=%h done_cyc=%0d want 00/5", DataResult, done_cyc);
    end
    c = '{8'd1, 8'd1, 8'd0, 8'd0, 8'd0};
    load_ops(8'hFF, 3'd1, c, 1);
    wait_result(1'b0);
    vectors++;
    if (DataResult !== 8'h00 || done_cyc !== 3) begin
      miscompares++;
      $display("FAIL wrap_add: res=%h done_cyc=%0d want 00/3", DataResult, done_cyc);
    end
  endtask

  task automatic test_clamp;
    logic [7:0] c [5];
    c = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
    load_ops(8'd2, 3'd7, c, 1);
    wait_result(1'b0);
    vectors++;
    if (DataResult !== 8'h1F || done_cyc !== 9) begin
      miscompares++;
      $display("FAIL clamp_result: res=%h done_cyc=%0d want 1f/9", DataResult, done_cyc);
    end
    vectors++;
    if (idx_seen.size() !== 5) begin
      miscompares++;
      $display("FAIL clamp_loads: count=%0d want 5", idx_seen.size());
    end
    for (int k = 0; k < idx_seen.size(); k++) begin
      vectors++;
      if (idx_seen[k] !== 3'(4 - k)) begin
        miscompares++;
        $display("FAIL clamp_coefidx[%0d]: got %0d want %0d", k, idx_seen[k], 4 - k);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] c [5];
    bit bad;
    c = '{8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'd0};
    load_ops(8'($urandom), 3'd3, c, 1);
    @(posedge Clock); #1;
    vectors++;
    if (Busy !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_busy: got %b want 1", Busy);
    end
    Resetn = 1'b0;
    @(posedge Clock); #1;
    vectors++;
    if (DataResult !== 8'h00 || Done !== 1'b0 || Busy !== 1'b0 || CoefIdx !== 3'd0) begin
      miscompares++;
      $display("FAIL midrst_state: res=%h done=%b busy=%b idx=%0d want 00/0/0/0",
               DataResult, Done, Busy, CoefIdx);
    end
    Resetn = 1'b1;
    bad = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (Done !== 1'b0 || DataResult !== 8'h00) bad = 1'b1;
      @(posedge Clock); #1;
    end
    vectors++;
    if (bad) begin
      miscompares++;
      $display("FAIL midrst_quiet: done/result changed after reset, want 0/00");
    end
    c = '{8'd2, 8'd1, 8'd0, 8'd0, 8'd0};
    load_ops(8'd5, 3'd1, c, 1);
    wait_result(1'b0);
    vectors++;
    if (DataResult !== 8'h0B || done_cyc !== 3) begin
      miscompares++;
      $display("FAIL midrst_rerun: res=%h done_cyc=%0d want 0b/3", DataResult, done_cyc);
    end
  endtask

  task automatic test_go_hold;
    logic [7:0] c [5];
    logic [7:0] xv;
    for (int k = 0; k < 5; k++) c[k] = 8'($urandom);
    xv = 8'($urandom);
    load_ops(xv, 3'd3, c, 20);
    wait_result(1'b0);
    vectors++;
    if (DataResult !== ref_eval(xv, 3, c) || done_cyc !== 7) begin
      miscompares++;
      $display("FAIL go_hold: res=%h done_cyc=%0d want %h/7",
               DataResult, done_cyc, ref_eval(xv, 3, c));
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] c [5];
    logic [7:0] xv;
    logic [2:0] dv;
    int n;
    for (int r = 0; r < 24; r++) begin
      for (int k = 0; k < 5; k++) c[k] = 8'($urandom);
      xv = 8'($urandom);
      dv = 3'($urandom_range(7, 0));
      n  = eff_deg(dv);
      load_ops(xv, dv, c, int'($urandom_range(4, 1)));
      wait_result(1'b1);
      vectors++;
      if (DataResult !== ref_eval(xv, n, c) || done_cyc !== 1 + 2 * n ||
          busy_cnt !== 1 + 2 * n) begin
        miscompares++;
        $display("FAIL b2b[%0d]: x=%h deg=%0d res=%h done_cyc=%0d busy=%0d want %h/%0d",
                 r, xv, dv, DataResult, done_cyc, busy_cnt, ref_eval(xv, n, c), 1 + 2 * n);
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    Resetn      = 1'b0;
    Go          = 1'b0;
    DataIn      = '0;
    Degree      = '0;
    test_reset();
    test_quadratic();
    test_deg0();
    test_wrap();
    test_clamp();
    test_reset_mid();
    test_go_hold();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
